// File: rtl/rsa_xcel_mont_mul_iter_if.sv
// Request/response val/rdy streams of the iterative Montgomery multiplier.
// The slave modport is the multiplier side, the master modport is the requester side.
interface rsa_xcel_mont_mul_iter_if #(
  parameter int p_nbits = 32
);
  logic               istream_val;
  logic               istream_rdy;
  logic [p_nbits-1:0] istream_x;
  logic [p_nbits-1:0] istream_y;
  logic [p_nbits-1:0] istream_n;
  logic               ostream_val;
  logic               ostream_rdy;
  logic [p_nbits-1:0] ostream_msg;

  modport slave (
    input  istream_val, istream_x, istream_y, istream_n, ostream_rdy,
    output istream_rdy, ostream_val, ostream_msg
  );

  modport master (
    output istream_val, istream_x, istream_y, istream_n, ostream_rdy,
    input  istream_rdy, ostream_val, ostream_msg
  );
endinterface

// File: rtl/rsa_xcel_mont_mul_iter.sv
// Iterative Montgomery multiplier: x*y*2^-p_nbits mod n, retiring
// p_bits_per_cycle bits of x per cycle, with the final conditional subtraction.
module rsa_xcel_mont_mul_iter #(
  parameter int p_nbits          = 32,
  parameter int p_bits_per_cycle = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  rsa_xcel_mont_mul_iter_if.slave       bus
);

  localparam int NI = p_nbits / p_bits_per_cycle;
  localparam int CW = (NI > 1) ? $clog2(NI) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NI - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [p_nbits-1:0] x_q, x_d;
  logic [p_nbits-1:0] y_q, y_d;
  logic [p_nbits-1:0] n_q, n_d;
  logic [p_nbits:0]   acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               irdy_q, irdy_d;
  logic               oval_q, oval_d;
  logic [p_nbits:0]   acc_s;
  logic               sub_s;
  logic [p_nbits-1:0] msg_s;

  // One add-reduce step; the sum is kept at p_nbits+2 bits, acc stays below 2n.
  function automatic logic [p_nbits:0] add_reduce(
    input logic [p_nbits:0]   acc,
    input logic               xb,
    input logic [p_nbits-1:0] y,
    input logic [p_nbits-1:0] n
  );
    logic [p_nbits+1:0] t;
    t = {1'b0, acc} + (xb ? {2'b00, y} : {(p_nbits+2){1'b0}});
    if (t[0]) begin
      t = t + {2'b00, n};
    end else begin
      t = t;
    end
    return t[p_nbits+1:1];
  endfunction

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    n_d     = n_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    acc_s   = acc_q;
    case (state_q)
      IDLE: begin
        if (bus.istream_val) begin
          state_d = CALC;
          x_d     = bus.istream_x;
          y_d     = bus.istream_y;
          n_d     = bus.istream_n;
          acc_d   = {(p_nbits+1){1'b0}};
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        for (int i = 0; i < p_bits_per_cycle; i++) begin
          acc_s = add_reduce(acc_s, x_q[i], y_q, n_q);
        end
        acc_d = acc_s;
        x_d   = x_q >> p_bits_per_cycle;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        if (bus.ostream_rdy) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Handshake flags follow the next state so they are flops, not decodes.
    irdy_d = (state_d == IDLE);
    oval_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= {p_nbits{1'b0}};
      y_q     <= {p_nbits{1'b0}};
      n_q     <= {p_nbits{1'b0}};
      acc_q   <= {(p_nbits+1){1'b0}};
      cnt_q   <= {CW{1'b0}};
      irdy_q  <= 1'b1;
      oval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      n_q     <= n_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      irdy_q  <= irdy_d;
      oval_q  <= oval_d;
    end
  end

  // Final reduction; the low bits of acc - n are exact whenever acc >= n.
  always_comb begin
    sub_s = (acc_q >= {1'b0, n_q});
    msg_s = sub_s ? (acc_q[p_nbits-1:0] - n_q) : acc_q[p_nbits-1:0];
  end

  assign bus.istream_rdy = irdy_q;
  assign bus.ostream_val = oval_q;
  assign bus.ostream_msg = msg_s;

endmodule

// File: tb/tb_rsa_xcel_mont_mul_iter.sv
// Scoreboard bench for rsa_xcel_mont_mul_iter: three instances with 1, 4 and 8
// bits per cycle, checked against a modular-arithmetic reference.
module tb_rsa_xcel_mont_mul_iter;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   cyc;

  logic        in_val [3];
  logic [31:0] in_x   [3];
  logic [31:0] in_y   [3];
  logic [31:0] in_n   [3];
  logic        out_rdy[3];
  logic        fixed_rdy[3];
  logic        rand_rdy;
  logic        in_rdy [3];
  logic        out_val[3];
  logic [31:0] out_msg[3];
  logic        prev_val[3];

  logic [31:0] exp_msg_q[3][$];
  int          exp_e_q  [3][$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : lane
    rsa_xcel_mont_mul_iter_if #(.p_nbits(32)) u_if ();
    assign u_if.istream_val = in_val[g];
    assign u_if.istream_x   = in_x[g];
    assign u_if.istream_y   = in_y[g];
    assign u_if.istream_n   = in_n[g];
    assign u_if.ostream_rdy = out_rdy[g];
    assign in_rdy[g]        = u_if.istream_rdy;
    assign out_val[g]       = u_if.ostream_val;
    assign out_msg[g]       = u_if.ostream_msg;
    rsa_xcel_mont_mul_iter #(
      .p_nbits(32),
      .p_bits_per_cycle((g == 0) ? 1 : ((g == 1) ? 4 : 8))
    ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (u_if.slave)
    );
  end

  function automatic int ni(input int l);
    return (l == 0) ? 32 : ((l == 1) ? 8 : 4);
  endfunction

  // Reference: (x*y mod n) multiplied 32 times by the inverse of 2 mod n.
  function automatic logic [31:0] mont_ref(input logic [31:0] x, input logic [31:0] y,
                                           input logic [31:0] n);
    logic [63:0] r;
    logic [63:0] half;
    r    = (64'(x) * 64'(y)) % 64'(n);
    half = (64'(n) + 64'd1) >> 1;
    for (int i = 0; i < 32; i++) r = (r * half) % 64'(n);
    return r[31:0];
  endfunction

  always @(posedge clk) begin
    #1;
    for (int l = 0; l < 3; l++)
      out_rdy[l] = rand_rdy ? ($urandom_range(3) != 0) : fixed_rdy[l];
  end

  // Monitor: latency on every rising ostream_val, data on every handshake.
  always @(negedge clk) begin
    for (int l = 0; l < 3; l++) begin
      if (!reset && out_val[l] && !prev_val[l]) begin
        tests++;
        if (exp_e_q[l].size() == 0) begin
          fails++;
          $display("FAIL spurious_val lane%0d: ostream_val=1, required 0 (nothing pending)", l);
        end else if (cyc != exp_e_q[l][0] + ni(l)) begin
          fails++;
          $display("FAIL latency lane%0d: %0d cycles, required %0d", l,
                   cyc - exp_e_q[l][0], ni(l));
        end
      end
      if (!reset && out_val[l] && out_rdy[l]) begin
        tests++;
        if (exp_msg_q[l].size() == 0) begin
          fails++;
          $display("FAIL unexpected_result lane%0d: msg=%h with empty scoreboard", l, out_msg[l]);
        end else begin
          if (out_msg[l] !== exp_msg_q[l][0]) begin
            fails++;
            $display("FAIL result lane%0d: got %h, required %h", l, out_msg[l], exp_msg_q[l][0]);
          end
          void'(exp_msg_q[l].pop_front());
          void'(exp_e_q[l].pop_front());
        end
      end
      prev_val[l] = out_val[l];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic send(input int l, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] n);
    int w;
    in_x[l]   = x;
    in_y[l]   = y;
    in_n[l]   = n;
    in_val[l] = 1'b1;
    w = 0;
    forever begin
      @(negedge clk);
      if (in_rdy[l]) break;
      w++;
      if (w > 300) break;
    end
    if (w > 300) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout lane%0d: istream_rdy=0 for 300 cycles, required 1", l);
    end else begin
      exp_msg_q[l].push_back(mont_ref(x, y, n));
      exp_e_q[l].push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    in_val[l] = 1'b0;
  endtask

  task automatic wait_drain(input int l, input int budget);
    int w;
    w = 0;
    while (exp_msg_q[l].size() != 0 && w < budget) begin
      @(negedge clk);
      w++;
    end
    if (exp_msg_q[l].size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout lane%0d: %0d results pending, required 0", l,
               exp_msg_q[l].size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    logic [31:0] n;
    tests    = 0;
    fails    = 0;
    cyc      = 0;
    rand_rdy = 1'b0;
    reset    = 1'b1;
    for (int l = 0; l < 3; l++) begin
      in_val[l]    = 1'b0;
      in_x[l]      = 32'd0;
      in_y[l]      = 32'd0;
      in_n[l]      = 32'd1;
      fixed_rdy[l] = 1'b1;
      prev_val[l]  = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    for (int l = 0; l < 3; l++) begin
      check($sformatf("reset_irdy%0d", l), 32'(in_rdy[l]), 32'd1);
      check($sformatf("reset_oval%0d", l), 32'(out_val[l]), 32'd0);
      check($sformatf("reset_msg%0d", l), out_msg[l], 32'd0);
    end
    @(posedge clk);
    #1;

    // Directed cases
    send(0, 32'd3, 32'd5, 32'd7);
    send(0, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
    wait_drain(0, 200);
    for (int l = 1; l < 3; l++) begin
      send(l, 32'd3, 32'd4, 32'd5);
      send(l, 32'd0, 32'd4, 32'd5);
      wait_drain(l, 100);
    end

    // Backpressure: hold ostream_rdy low in DONE for 10 cycles
    fixed_rdy[0] = 1'b0;
    @(posedge clk);
    #1;
    send(0, 32'd3, 32'd5, 32'd7);
    w = 0;
    while (!out_val[0] && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("stall_reach_done", 32'(out_val[0]), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_val", 32'(out_val[0]), 32'd1);
      check("stall_msg", out_msg[0], 32'd2);
      check("stall_irdy", 32'(in_rdy[0]), 32'd0);
    end
    fixed_rdy[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("release_irdy", 32'(in_rdy[0]), 32'd1);
    check("release_oval", 32'(out_val[0]), 32'd0);
    @(posedge clk);
    #1;

    // Reset in the tenth CALC cycle
    send(0, 32'd3, 32'd5, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    exp_msg_q[0].delete();
    exp_e_q[0].delete();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midreset_irdy", 32'(in_rdy[0]), 32'd1);
    check("midreset_oval", 32'(out_val[0]), 32'd0);
    check("midreset_msg", out_msg[0], 32'd0);
    w = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_val[0]) w++;
    end
    check("midreset_no_val", 32'(w), 32'd0);
    @(posedge clk);
    #1;
    send(0, 32'd1, 32'd1, 32'd3);
    wait_drain(0, 100);

    // Randomized traffic with throttling on both streams
    rand_rdy = 1'b1;
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < ((l == 0) ? 1000 : 200); i++) begin
        repeat ($urandom_range(2)) @(posedge clk);
        #1;
        n = $urandom | 32'd1;
        send(l, $urandom % n, $urandom % n, n);
      end
      wait_drain(l, 400);
    end
    rand_rdy = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
